// File: rtl/mem_access_ctrl_pkg.sv
// Shared MEM-stage definitions: controller states, write-back select codes
// and the MEM/WB bubble value.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic        regwrite;
    logic [1:0]  memtoreg;
    logic [31:0] aluout;
    logic [31:0] memdata;
    logic [4:0]  regwraddr;
  } wb_fields_t;

  localparam wb_fields_t WB_BUBBLE = '{
    pc:        '0,
    regwrite:  1'b0,
    memtoreg:  MTR_ALU,
    aluout:    '0,
    memdata:   '0,
    regwraddr: '0
  };

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble loads an all-zero, non-writing entry.
module mem_wb_reg
  import mem_access_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       bubble,
  input  wb_fields_t d,
  output wb_fields_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       q <= WB_BUBBLE;
    else if (bubble) q <= WB_BUBBLE;
    else             q <= d;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: word-aligned req/ack bus access
// with stall, timeout and misalignment detection, feeding the MEM/WB register.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_pc,
  input  logic        mem_regwrite,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  input  logic [1:0]  mem_memtoreg,
  input  logic [31:0] mem_aluout,
  input  logic [31:0] mem_rtdata,
  input  logic [4:0]  mem_regwraddr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_aluout,
  output logic [31:0] wb_memdata,
  output logic        wb_regwrite,
  output logic [1:0]  wb_memtoreg,
  output logic [4:0]  wb_regwraddr,
  output logic        misalign_fault,
  output logic        timeout_fault,
  output logic [31:0] fault_pc
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [CW-1:0] cnt;
  logic [31:0] rdata_q;
  logic        killed;
  logic        access, aligned, is_read;
  logic        wb_bubble;
  wb_fields_t  wb_d, wb_q;

  assign access  = mem_memread | mem_memwrite;
  assign aligned = (mem_aluout[1:0] == 2'b00);
  assign is_read = mem_memread;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (access && aligned) state_next = ST_BUSY;
      ST_BUSY: if (bus_ack || cnt == CNT_LAST) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // stall is held low during reset so an abandoned access never freezes the pipe
  always_comb begin
    stall     = 1'b0;
    wb_bubble = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access && aligned) stall     = 1'b1;
        else if (access)       wb_bubble = 1'b1;
      end
      ST_BUSY: stall = 1'b1;
      default: ;
    endcase
    if (reset) stall = 1'b0;
    wb_bubble = wb_bubble | stall;

    wb_d           = WB_BUBBLE;
    wb_d.pc        = mem_pc;
    wb_d.regwrite  = mem_regwrite & ~((state == ST_DONE) & killed);
    wb_d.memtoreg  = mem_memtoreg;
    wb_d.aluout    = mem_aluout;
    wb_d.regwraddr = mem_regwraddr;
    if (state == ST_DONE && is_read && !killed) wb_d.memdata = rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
      cnt            <= '0;
      rdata_q        <= '0;
      killed         <= 1'b0;
      misalign_fault <= 1'b0;
      timeout_fault  <= 1'b0;
      fault_pc       <= '0;
    end else begin
      misalign_fault <= 1'b0;
      timeout_fault  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access && aligned) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_memwrite & ~mem_memread;
            bus_addr  <= {mem_aluout[31:2], 2'b00};
            bus_wdata <= mem_rtdata;
            cnt       <= '0;
            killed    <= 1'b0;
          end else if (access) begin
            misalign_fault <= 1'b1;
            fault_pc       <= mem_pc;
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            if (!bus_we) rdata_q <= bus_rdata;
            bus_req <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            bus_req       <= 1'b0;
            timeout_fault <= 1'b1;
            fault_pc      <= mem_pc;
            killed        <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .reset  (reset),
    .bubble (wb_bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign wb_pc        = wb_q.pc;
  assign wb_aluout    = wb_q.aluout;
  assign wb_memdata   = wb_q.memdata;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_memtoreg  = wb_q.memtoreg;
  assign wb_regwraddr = wb_q.regwraddr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT=4.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_pc;
  logic        mem_regwrite, mem_memread, mem_memwrite;
  logic [1:0]  mem_memtoreg;
  logic [31:0] mem_aluout, mem_rtdata;
  logic [4:0]  mem_regwraddr;
  logic        bus_req, bus_we, bus_ack, stall;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [31:0] wb_pc, wb_aluout, wb_memdata, fault_pc;
  logic        wb_regwrite, misalign_fault, timeout_fault;
  logic [1:0]  wb_memtoreg;
  logic [4:0]  wb_regwraddr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .mem_pc(mem_pc), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg), .mem_aluout(mem_aluout),
    .mem_rtdata(mem_rtdata), .mem_regwraddr(mem_regwraddr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(stall),
    .wb_pc(wb_pc), .wb_aluout(wb_aluout), .wb_memdata(wb_memdata),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_regwraddr(wb_regwraddr),
    .misalign_fault(misalign_fault), .timeout_fault(timeout_fault), .fault_pc(fault_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic rw, input logic mr, input logic mw,
                       input logic [1:0] mtr, input logic [31:0] alu, input logic [31:0] rt,
                       input logic [4:0] rd);
    mem_pc = pc; mem_regwrite = rw; mem_memread = mr; mem_memwrite = mw;
    mem_memtoreg = mtr; mem_aluout = alu; mem_rtdata = rt; mem_regwraddr = rd;
  endtask

  task automatic nop();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    nop();
    #2;
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_wb_regwrite", {31'b0, wb_regwrite}, 32'd0);
    chk("rst_wb_aluout", wb_aluout, 32'd0);
    chk("rst_faults", {30'b0, misalign_fault, timeout_fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    tick();
    reset = 1'b0;

    // ALU op pass-through
    drive(32'h40, 1'b1, 1'b0, 1'b0, 2'b00, 32'h1234, 32'h0, 5'd5);
    #1 chk("alu_stall", {31'b0, stall}, 32'd0);
    tick();
    nop();
    chk("alu_wb_aluout", wb_aluout, 32'h1234);
    chk("alu_wb_rd", {27'b0, wb_regwraddr}, 32'd5);
    chk("alu_wb_regwrite", {31'b0, wb_regwrite}, 32'd1);
    chk("alu_wb_pc", wb_pc, 32'h40);
    chk("alu_wb_memdata", wb_memdata, 32'd0);
    tick();

    // Zero-wait load from 0x100
    drive(32'h44, 1'b1, 1'b1, 1'b0, 2'b01, 32'h100, 32'h0, 5'd7);
    #1 chk("ld_stall_idle", {31'b0, stall}, 32'd1);
    tick();
    chk("ld_bus_req", {31'b0, bus_req}, 32'd1);
    chk("ld_bus_addr", bus_addr, 32'h100);
    chk("ld_bus_we", {31'b0, bus_we}, 32'd0);
    chk("ld_stall_busy", {31'b0, stall}, 32'd1);
    chk("ld_wb_bubble", {31'b0, wb_regwrite}, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk("ld_done_bus_req", {31'b0, bus_req}, 32'd0);
    chk("ld_done_stall", {31'b0, stall}, 32'd0);
    chk("ld_done_wb_regwrite", {31'b0, wb_regwrite}, 32'd0);
    tick();
    nop();
    chk("ld_wb_memdata", wb_memdata, 32'hDEADBEEF);
    chk("ld_wb_regwrite", {31'b0, wb_regwrite}, 32'd1);
    chk("ld_wb_memtoreg", {30'b0, wb_memtoreg}, 32'd1);
    chk("ld_wb_rd", {27'b0, wb_regwraddr}, 32'd7);
    tick();
    chk("ld_single_pulse", {31'b0, wb_regwrite}, 32'd0);

    // Store with 3 wait states; ack lands on the last allowed cycle
    drive(32'h48, 1'b0, 1'b0, 1'b1, 2'b00, 32'h200, 32'hCAFEF00D, 5'd0);
    #1 chk("st_stall_idle", {31'b0, stall}, 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("st_bus_req", {31'b0, bus_req}, 32'd1);
      chk("st_bus_we", {31'b0, bus_we}, 32'd1);
      chk("st_bus_addr", bus_addr, 32'h200);
      chk("st_bus_wdata", bus_wdata, 32'hCAFEF00D);
      chk("st_stall_busy", {31'b0, stall}, 32'd1);
      if (i == 3) bus_ack = 1'b1;
      tick();
    end
    bus_ack = 1'b0;
    chk("st_done_bus_req", {31'b0, bus_req}, 32'd0);
    chk("st_done_stall", {31'b0, stall}, 32'd0);
    chk("st_no_timeout", {31'b0, timeout_fault}, 32'd0);
    tick();
    nop();
    chk("st_wb_regwrite", {31'b0, wb_regwrite}, 32'd0);
    chk("st_wb_memdata", wb_memdata, 32'd0);
    chk("st_wb_pc", wb_pc, 32'h48);
    tick();

    // Misaligned load
    drive(32'h4C, 1'b1, 1'b1, 1'b0, 2'b01, 32'h103, 32'h0, 5'd3);
    #1 chk("mis_stall", {31'b0, stall}, 32'd0);
    tick();
    nop();
    chk("mis_fault", {31'b0, misalign_fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h4C);
    chk("mis_bus_req", {31'b0, bus_req}, 32'd0);
    chk("mis_wb_regwrite", {31'b0, wb_regwrite}, 32'd0);
    tick();
    chk("mis_fault_pulse", {31'b0, misalign_fault}, 32'd0);

    // Timeout: no ack for 4 cycles
    drive(32'h50, 1'b1, 1'b1, 1'b0, 2'b01, 32'h300, 32'h0, 5'd8);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_bus_req", {31'b0, bus_req}, 32'd1);
      chk("to_fault_early", {31'b0, timeout_fault}, 32'd0);
      tick();
    end
    chk("to_done_bus_req", {31'b0, bus_req}, 32'd0);
    chk("to_fault", {31'b0, timeout_fault}, 32'd1);
    chk("to_fault_pc", fault_pc, 32'h50);
    chk("to_done_stall", {31'b0, stall}, 32'd0);
    tick();
    nop();
    chk("to_wb_regwrite", {31'b0, wb_regwrite}, 32'd0);
    chk("to_fault_pulse", {31'b0, timeout_fault}, 32'd0);
    tick();

    // Reset in the 2nd BUSY cycle
    drive(32'h54, 1'b1, 1'b1, 1'b0, 2'b01, 32'h400, 32'h0, 5'd4);
    tick();
    tick();
    chk("rb_bus_req_pre", {31'b0, bus_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rb_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rb_stall", {31'b0, stall}, 32'd0);
    nop();
    tick();
    reset = 1'b0;
    chk("rb_no_fault", {30'b0, misalign_fault, timeout_fault}, 32'd0);
    drive(32'h58, 1'b1, 1'b0, 1'b0, 2'b00, 32'h55AA, 32'h0, 5'd9);
    #1 chk("rb_alu_stall", {31'b0, stall}, 32'd0);
    tick();
    nop();
    chk("rb_wb_aluout", wb_aluout, 32'h55AA);
    chk("rb_wb_regwrite", {31'b0, wb_regwrite}, 32'd1);
    chk("rb_wb_rd", {27'b0, wb_regwraddr}, 32'd9);
    chk("rb_bus_req_after", {31'b0, bus_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
